alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream stage of the 8-bit ALU/OR datapath.
- Captures operand A, operand B and a 6-bit opcode from a shared 8-bit switch bank, one value per debounced button press, in a fixed order.
- Presents the three values to the ALU with a valid/ready handshake.
- The ALU's 8-bit A/B inputs are driven directly from o_a/o_b.

Parameters:
- DATA_W, 8: operand width; must match the ALU A/B width.
- OP_W, 6: opcode width; taken from i_sw[OP_W-1:0].
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a button level change. Must be ≥2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sw  in  DATA_W  raw switch bank.
- i_btn_a  in  1  raw button: load A.
- i_btn_b  in  1  raw button: load B.
- i_btn_op  in  1  raw button: load opcode.
- i_ready  in  1  ALU/consumer accepts the operand set.
- o_a  out  DATA_W  operand A register.
- o_b  out  DATA_W  operand B register.
- o_op  out  OP_W  opcode register.
- o_valid  out  1  full operand set available.
- o_state  out  2  FSM state, for LEDs.

Behaviour:
- Reset (async, i_rst_n low): o_a=0, o_b=0, o_op=0, o_valid=0, o_state=WAIT_A(0). Debounced levels=0, debounce counters=0, press pulses=0.
- Reset asserted mid-sequence discards any partially loaded set.
- Debounce (per button):
  - Counter increments while the raw level differs from the debounced level; clears to 0 when they are equal.
  - After DEBOUNCE_CYCLES consecutive differing samples, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never flip the level.
- Press event: one-cycle pulse on a debounced rising edge only. Release generates nothing. Holding a button yields exactly one event.
- Latency: raw button high sampled at edges t..t+N-1 (N=DEBOUNCE_CYCLES), so the debounced level goes high after edge t+N-1. The register capture happens at edge t+N and is visible after it.
- i_sw is sampled at the capture edge, not at the press.
- FSM states (o_state encoding):
  - WAIT_A=0: press_a → o_a<=i_sw; go to WAIT_B.
  - WAIT_B=1: press_b → o_b<=i_sw; go to WAIT_OP.
  - WAIT_OP=2: press_op → o_op<=i_sw[OP_W-1:0]; go to READY; o_valid=1 from the next cycle.
  - READY=3: o_valid=1. When i_ready=1 on an edge, the transfer completes: o_valid<=0, go to WAIT_A.
- Presses of a non-matching button in any state are ignored and do not alter registers.
- Simultaneous press events: only the button matching the current state acts.
- All presses are ignored in READY.
- o_a/o_b/o_op hold their values between loads. They are never cleared except by reset, so the ALU keeps seeing the last operands after a transfer.
- i_ready outside READY has no effect.
- Handshake: o_valid stays high until accepted. There is no combinational path from i_ready to o_valid.

Optional Feature:
- Macro: ALU_LOADER_INPUT_SYNC_EN.
- Defined: a 2-flop synchronizer is inserted on each raw button and on i_sw before the debounce/capture logic. Synchronizer flops reset to 0. All press latencies grow by exactly 2 cycles (capture at edge t+N+2), and captured switch values are those present 2 cycles earlier.
- Undefined: raw inputs feed the debounce/capture logic directly, with the latencies stated above.

Decomposition:
- Shared package alu_pkg: DATA_W and OP_W constants, and the state typedef/encodings WAIT_A=2'd0, WAIT_B=2'd1, WAIT_OP=2'd2, READY=2'd3.
- One natural sub-module, btn_debounce: raw in, debounced level and press pulse out, parameterized by DEBOUNCE_CYCLES. Instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: i_rst_n=0 mid-WAIT_OP with o_a=8'hF0 → all outputs 0 and o_state=0 immediately, without a clock edge.
- Normal load: sw=8'hF0, press btn_a 10 cycles; sw=8'h0C, press btn_b; sw=8'h25, press btn_op → o_a=F0, o_b=0C, o_op=6'h25, o_valid=1, o_state=3. The ALU's OR output reads 8'hFC.
- Debounce: a 3-cycle btn_a pulse → no capture, state stays 0. A 4-cycle pulse → o_a captured at the 5th edge after the rise.
- Ordering: press btn_b, then btn_op, while in WAIT_A → o_b and o_op unchanged, state 0. Simultaneous a+b press in WAIT_A → only o_a loads.
- Handshake: in READY hold i_ready=0 for 20 cycles while pressing btn_a → o_valid stays 1, o_a unchanged. Pulse i_ready=1 → o_valid=0 next cycle, state 0, o_a/o_b/o_op retained.
- Held button: btn_a held high 50 cycles → exactly one capture. With ALU_LOADER_INPUT_SYNC_EN defined, the capture lands exactly 2 cycles later than without it.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU/OR datapath.
//   ALU_DATA_W : operand width seen by the ALU A/B inputs
//   ALU_OP_W   : opcode width
//   state_e    : operand loader FSM state; the encoding is also shown on the LEDs
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 6;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// btn_debounce: debounces one raw push-button and emits a single-cycle press
// pulse on each debounced rising edge. A release produces no pulse.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_raw          : raw button level
//   o_level        : debounced level
//   o_press        : one-cycle pulse, registered together with the level flip
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // The counter holds the number of consecutive differing samples already seen;
  // the Nth differing sample flips the level instead of counting further.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (i_raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = i_raw;
        press_d = i_raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures operand A, operand B and an opcode from a shared
// switch bank, one value per debounced button press in the fixed order A, B, OP,
// then offers the set to the ALU with a valid/ready handshake.
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_sw[DATA_W]             : raw switch bank
//   i_btn_a/i_btn_b/i_btn_op : raw load buttons
//   i_ready                  : consumer accepts the operand set (only in READY)
//   o_a, o_b [DATA_W]        : operand registers, held until reloaded
//   o_op [OP_W]              : opcode register
//   o_valid                  : full operand set available
//   o_state [2]              : FSM state for LEDs
// Build option: define ALU_LOADER_INPUT_SYNC_EN to put a 2-flop synchronizer on
// every button and on i_sw (adds 2 cycles of latency to every capture).
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int DATA_W          = ALU_DATA_W,
  parameter int OP_W            = ALU_OP_W,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [OP_W-1:0]   o_op,
  output logic              o_valid,
  output logic [1:0]        o_state
);

  // bit 0 = A, bit 1 = B, bit 2 = OP
  logic [2:0]        btn_raw;
  logic [DATA_W-1:0] sw_cap;
  logic [2:0]        press;
  logic [2:0]        level;

`ifdef ALU_LOADER_INPUT_SYNC_EN
  logic [2:0]        btn_s1_q, btn_s2_q;
  logic [DATA_W-1:0] sw_s1_q, sw_s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= {i_btn_op, i_btn_b, i_btn_a};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= i_sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  assign btn_raw = btn_s2_q;
  assign sw_cap  = sw_s2_q;
`else
  assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};
  assign sw_cap  = i_sw;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (btn_raw[g]),
      .o_level (level[g]),
      .o_press (press[g])
    );
  end

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  logic unused_level;
  assign unused_level = &{1'b0, level};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;

  // Only the button matching the current state acts; everything else,
  // including every press while in READY, is dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    case (state_q)
      WAIT_A: if (press[0]) begin
        a_d     = sw_cap;
        state_d = WAIT_B;
      end
      WAIT_B: if (press[1]) begin
        b_d     = sw_cap;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (press[2]) begin
        op_d    = sw_cap[OP_W-1:0];
        state_d = READY;
        valid_d = 1'b1;
      end
      READY: if (i_ready) begin
        valid_d = 1'b0;
        state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_op    = op_q;
  assign o_valid = valid_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Testbench for alu_operand_loader with DEBOUNCE_CYCLES=4: directed scenarios
// with literal expectations, then randomized button/switch/ready traffic checked
// every cycle against a sample-window reference model.
module tb_alu_operand_loader;

  localparam int N = 4;
`ifdef ALU_LOADER_INPUT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_sw;
  logic       i_btn_a, i_btn_b, i_btn_op, i_ready;
  logic [7:0] o_a, o_b;
  logic [5:0] o_op;
  logic       o_valid;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_operand_loader #(.DATA_W(8), .OP_W(6), .DEBOUNCE_CYCLES(N)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sw     (i_sw),
    .i_btn_a  (i_btn_a),
    .i_btn_b  (i_btn_b),
    .i_btn_op (i_btn_op),
    .i_ready  (i_ready),
    .o_a      (o_a),
    .o_b      (o_b),
    .o_op     (o_op),
    .o_valid  (o_valid),
    .o_state  (o_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every clock edge records the raw inputs. The value seen by the loader at
  // edge j is the raw record of edge j-SYNC (zero before that exists). A
  // button's debounced level flips at an edge when the last N seen samples all
  // differ from it; a rising flip is a press that acts on the following edge.
  logic [10:0] hist[$];   // {op, b, a, sw}
  logic [2:0]  m_lvl, m_pend;
  logic [7:0]  m_a, m_b;
  logic [5:0]  m_op;
  logic        m_valid;
  int          m_state;
  int          mk;
  logic [10:0] m_e;
  logic        m_all;

  function automatic logic [10:0] seen(input int j);
    if (j - SYNC >= 0) return hist[j - SYNC];
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_lvl = '0; m_pend = '0;
      m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_state = 0;
    end else begin
      hist.push_back({i_btn_op, i_btn_b, i_btn_a, i_sw});
      mk  = hist.size() - 1;
      m_e = seen(mk);
      if (m_state == 3) begin
        if (i_ready) begin m_valid = 1'b0; m_state = 0; end
      end else if (m_state == 0 && m_pend[0]) begin
        m_a = m_e[7:0]; m_state = 1;
      end else if (m_state == 1 && m_pend[1]) begin
        m_b = m_e[7:0]; m_state = 2;
      end else if (m_state == 2 && m_pend[2]) begin
        m_op = m_e[5:0]; m_state = 3; m_valid = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 1'b0;
        if (mk >= N - 1) begin
          m_all = 1'b1;
          for (int j = mk - N + 1; j <= mk; j++)
            if (seen(j)[8+i] == m_lvl[i]) m_all = 1'b0;
          if (m_all) begin
            m_lvl[i]  = ~m_lvl[i];
            m_pend[i] = m_lvl[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("model o_a", o_a, m_a);
      chk("model o_b", o_b, m_b);
      chk("model o_op", o_op, m_op);
      chk("model o_valid", o_valid, m_valid);
      chk("model o_state", o_state, m_state);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] mask, input logic [7:0] sw, input int hold);
    i_sw = sw;
    {i_btn_op, i_btn_b, i_btn_a} = mask;
    tick(hold);
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    tick(N + SYNC + 4);
  endtask

  initial begin
    rst_n = 1'b0;
    i_sw = '0; i_btn_a = 0; i_btn_b = 0; i_btn_op = 0; i_ready = 0;
    #22;
    chk("reset o_a", o_a, 8'h00);
    chk("reset o_valid", o_valid, 1'b0);
    chk("reset o_state", o_state, 2'd0);
    @(negedge clk) rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // normal load
    press(3'b001, 8'hF0, 10);
    press(3'b010, 8'h0C, 10);
    press(3'b100, 8'h25, 10);
    chk("load o_a", o_a, 8'hF0);
    chk("load o_b", o_b, 8'h0C);
    chk("load o_op", o_op, 6'h25);
    chk("load o_valid", o_valid, 1'b1);
    chk("load o_state", o_state, 2'd3);
    chk("load alu or", o_a | o_b, 8'hFC);

    // handshake: presses ignored while waiting for ready
    press(3'b001, 8'h33, 10);
    chk("hold o_valid", o_valid, 1'b1);
    chk("hold o_a", o_a, 8'hF0);
    i_ready = 1'b1;
    tick(1);
    i_ready = 1'b0;
    chk("xfer o_valid", o_valid, 1'b0);
    chk("xfer o_state", o_state, 2'd0);
    chk("xfer o_a kept", o_a, 8'hF0);
    chk("xfer o_b kept", o_b, 8'h0C);
    chk("xfer o_op kept", o_op, 6'h25);

    // debounce: short glitch, then minimal-length press with exact timing
    press(3'b001, 8'hAA, N - 1);
    chk("glitch o_a", o_a, 8'hF0);
    chk("glitch o_state", o_state, 2'd0);
    i_sw = 8'hAA;
    i_btn_a = 1'b1;
    tick(N);
    i_btn_a = 1'b0;
    tick(SYNC);
    chk("edge N o_a", o_a, 8'hF0);
    tick(1);
    chk("edge N+1 o_a", o_a, 8'hAA);
    chk("edge N+1 o_state", o_state, 2'd1);
    tick(N + SYNC + 4);

    // asynchronous reset in WAIT_OP
    press(3'b010, 8'h0C, 10);
    chk("pre-reset o_state", o_state, 2'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst o_a", o_a, 8'h00);
    chk("async rst o_b", o_b, 8'h00);
    chk("async rst o_state", o_state, 2'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // ordering
    press(3'b010, 8'h11, 10);
    press(3'b100, 8'h22, 10);
    chk("order o_b", o_b, 8'h00);
    chk("order o_op", o_op, 6'h00);
    chk("order o_state", o_state, 2'd0);
    press(3'b011, 8'h5A, 10);
    chk("simul o_a", o_a, 8'h5A);
    chk("simul o_b", o_b, 8'h00);
    chk("simul o_state", o_state, 2'd1);

    // long hold yields one capture of the value present at capture time
    press(3'b010, 8'h77, 50);
    chk("held o_b", o_b, 8'h77);
    chk("held o_state", o_state, 2'd2);
    press(3'b100, 8'h3F, 10);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    i_sw = 8'hC3;
    i_btn_a = 1'b1;
    tick(N + SYNC + 2);
    i_sw = 8'h3C;
    tick(50 - (N + SYNC + 2));
    i_btn_a = 1'b0;
    tick(N + SYNC + 4);
    chk("held a o_a", o_a, 8'hC3);
    chk("held a o_state", o_state, 2'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) i_btn_a = ~i_btn_a;
      if ($urandom_range(0, 7) == 0) i_btn_b = ~i_btn_b;
      if ($urandom_range(0, 7) == 0) i_btn_op = ~i_btn_op;
      i_sw    = 8'($urandom);
      i_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick(1);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
